// File: rtl/uart_mmio_responder_if.sv
// ============================================================================
// Module      : uart_mmio_responder_if
// Description : CPU IO strobe bus plus UART TX/RX ready/valid byte streams.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_mmio_responder_if;
    logic        io_re;
    logic        io_we;
    logic [31:0] io_addr;
    logic [7:0]  io_wdata;
    logic [31:0] io_rdata;
    logic [7:0]  uart_din;
    logic        uart_din_valid;
    logic        uart_din_ready;
    logic [7:0]  uart_dout;
    logic        uart_dout_valid;
    logic        uart_dout_ready;

    modport master (
        output io_re, io_we, io_addr, io_wdata, uart_din_ready, uart_dout, uart_dout_valid,
        input  io_rdata, uart_din, uart_din_valid, uart_dout_ready
    );

    modport slave (
        input  io_re, io_we, io_addr, io_wdata, uart_din_ready, uart_dout, uart_dout_valid,
        output io_rdata, uart_din, uart_din_valid, uart_dout_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_mmio_responder.sv
// ============================================================================
// Module      : uart_mmio_responder
// Description : MMIO window for a UART with TX/RX byte FIFOs and sticky status.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_mmio_responder #(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    uart_mmio_responder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [31:0]   c_addr_txrdy  = 32'h8000_0000;
    localparam logic [31:0]   c_addr_rxvld  = 32'h8000_0004;
    localparam logic [31:0]   c_addr_din    = 32'h8000_0008;
    localparam logic [31:0]   c_addr_dout   = 32'h8000_000C;
    localparam logic [31:0]   c_addr_status = 32'h8000_0010;
    localparam logic [CW-1:0] c_depth       = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] c_cnt_one     = CW'(1);
    localparam logic [AW-1:0] c_ptr_one     = AW'(1);

    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wp, r_tx_rp;
    logic [CW-1:0] r_tx_cnt;
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rx_wp, r_rx_rp;
    logic [CW-1:0] r_rx_cnt;
    logic          r_tx_drop, r_rx_ovr;
    logic [31:0]   r_rdata;

    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic        w_tx_push_req, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic        w_sticky_clr;
    logic [31:0] w_rd_data;

    assign w_tx_full  = (r_tx_cnt == c_depth);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == c_depth);
    assign w_rx_empty = (r_rx_cnt == '0);

    // Fullness is judged on the start-of-cycle count, so a same-cycle pop
    // never rescues a push into a full TX FIFO.
    assign w_tx_push_req = bus.io_we & (bus.io_addr == c_addr_din);
    assign w_tx_push     = w_tx_push_req & ~w_tx_full;
    assign w_tx_pop      = ~w_tx_empty & bus.uart_din_ready;
    assign w_rx_push     = bus.uart_dout_valid & ~w_rx_full;
    assign w_rx_pop      = bus.io_re & (bus.io_addr == c_addr_dout) & ~w_rx_empty;
    assign w_sticky_clr  = bus.io_we & (bus.io_addr == c_addr_status);

    assign bus.uart_din        = r_tx_mem[r_tx_rp];
    assign bus.uart_din_valid  = ~w_tx_empty;
    assign bus.uart_dout_ready = ~w_rx_full;
    assign bus.io_rdata        = r_rdata;

    always_comb begin
        w_rd_data = '0;
        case (bus.io_addr)
            c_addr_txrdy:  w_rd_data = {31'b0, ~w_tx_full};
            c_addr_rxvld:  w_rd_data = {31'b0, ~w_rx_empty};
            c_addr_dout:   w_rd_data = w_rx_empty ? 32'b0 : {24'b0, r_rx_mem[r_rx_rp]};
            c_addr_status: w_rd_data = {30'b0, r_rx_ovr, r_tx_drop};
            default:       w_rd_data = '0;
        endcase
    end

    // Storage arrays need no reset: the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.io_wdata;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.uart_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wp   <= '0;
            r_tx_rp   <= '0;
            r_tx_cnt  <= '0;
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_rx_cnt  <= '0;
            r_tx_drop <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + c_ptr_one;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_ptr_one;
            if (w_rx_push) r_rx_wp <= r_rx_wp + c_ptr_one;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_ptr_one;

            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + c_cnt_one;
                2'b01:   r_tx_cnt <= r_tx_cnt - c_cnt_one;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + c_cnt_one;
                2'b01:   r_rx_cnt <= r_rx_cnt - c_cnt_one;
                default: r_rx_cnt <= r_rx_cnt;
            endcase

            // A set event in the same cycle as a clear keeps the bit high.
            r_tx_drop <= (w_tx_push_req & w_tx_full) | (r_tx_drop & ~w_sticky_clr);
            r_rx_ovr  <= (bus.uart_dout_valid & w_rx_full) | (r_rx_ovr & ~w_sticky_clr);

            if (bus.io_re) r_rdata <= w_rd_data;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_responder.sv
// ============================================================================
// Module      : tb_uart_mmio_responder
// Description : Queue-based reference model plus directed UART MMIO scenarios.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_mmio_responder;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    uart_mmio_responder_if bus ();

    uart_mmio_responder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic        m_drop, m_ovr;
    logic [31:0] m_rdata;
    logic [31:0] m_val;
    bit          m_txfull, m_rxfull, m_rxempty, m_set_drop, m_set_ovr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txq.delete();
            rxq.delete();
            m_drop  = 1'b0;
            m_ovr   = 1'b0;
            m_rdata = '0;
        end else begin
            m_txfull  = (txq.size() == DEPTH);
            m_rxfull  = (rxq.size() == DEPTH);
            m_rxempty = (rxq.size() == 0);
            case (bus.io_addr)
                32'h8000_0000: m_val = m_txfull ? 32'd0 : 32'd1;
                32'h8000_0004: m_val = m_rxempty ? 32'd0 : 32'd1;
                32'h8000_000C: m_val = m_rxempty ? 32'd0 : {24'd0, rxq[0]};
                32'h8000_0010: m_val = {30'd0, m_ovr, m_drop};
                default:       m_val = 32'd0;
            endcase
            if (bus.io_re) m_rdata = m_val;
            m_set_drop = 1'b0;
            m_set_ovr  = 1'b0;
            if (txq.size() != 0 && bus.uart_din_ready) void'(txq.pop_front());
            if (bus.io_we && bus.io_addr == 32'h8000_0008) begin
                if (m_txfull) m_set_drop = 1'b1;
                else          txq.push_back(bus.io_wdata);
            end
            if (bus.io_re && bus.io_addr == 32'h8000_000C && !m_rxempty) void'(rxq.pop_front());
            if (bus.uart_dout_valid) begin
                if (m_rxfull) m_set_ovr = 1'b1;
                else          rxq.push_back(bus.uart_dout);
            end
            if (bus.io_we && bus.io_addr == 32'h8000_0010) begin
                m_drop = 1'b0;
                m_ovr  = 1'b0;
            end
            if (m_set_drop) m_drop = 1'b1;
            if (m_set_ovr)  m_ovr  = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        chk("model_rdata", bus.io_rdata, m_rdata);
        chk("model_din_valid", {31'd0, bus.uart_din_valid}, {31'd0, txq.size() != 0});
        if (txq.size() != 0) chk("model_din", {24'd0, bus.uart_din}, {24'd0, txq[0]});
        chk("model_dout_ready", {31'd0, bus.uart_dout_ready}, {31'd0, rxq.size() < DEPTH});
    end

    // ---------------- stimulus helpers ----------------
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        @(negedge clk);
        bus.io_re   = 1'b1;
        bus.io_addr = addr;
        @(negedge clk);
        bus.io_re   = 1'b0;
        chk(name, bus.io_rdata, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.io_we    = 1'b1;
        bus.io_addr  = addr;
        bus.io_wdata = data;
        @(negedge clk);
        bus.io_we    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.io_re = 1'b0;
        bus.io_we = 1'b0;
        bus.io_addr = '0;
        bus.io_wdata = '0;
        bus.uart_din_ready = 1'b0;
        bus.uart_dout = '0;
        bus.uart_dout_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        rd(32'h8000_0000, 32'd1, "rst_txrdy");
        rd(32'h8000_0004, 32'd0, "rst_rxvld");
        chk("rst_din_valid", {31'd0, bus.uart_din_valid}, 32'd0);
        chk("rst_dout_ready", {31'd0, bus.uart_dout_ready}, 32'd1);

        // TX ordering
        wr(32'h8000_0008, 8'h41);
        wr(32'h8000_0008, 8'h42);
        chk("tx_valid", {31'd0, bus.uart_din_valid}, 32'd1);
        chk("tx_head0", {24'd0, bus.uart_din}, 32'h41);
        bus.uart_din_ready = 1'b1;
        @(negedge clk);
        chk("tx_head1", {24'd0, bus.uart_din}, 32'h42);
        @(negedge clk);
        bus.uart_din_ready = 1'b0;
        chk("tx_drained", {31'd0, bus.uart_din_valid}, 32'd0);

        // TX full / drop
        for (int i = 0; i < 5; i++) wr(32'h8000_0008, 8'h10 + 8'(i));
        rd(32'h8000_0000, 32'd0, "txfull_rdy");
        rd(32'h8000_0010, 32'd1, "txfull_drop");
        bus.uart_din_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("txfull_byte", {24'd0, bus.uart_din}, 32'h10 + i);
            @(negedge clk);
        end
        bus.uart_din_ready = 1'b0;
        chk("txfull_empty", {31'd0, bus.uart_din_valid}, 32'd0);
        wr(32'h8000_0010, 8'h00);
        rd(32'h8000_0010, 32'd0, "drop_cleared");

        // Unmapped addresses
        wr(32'h8000_0018, 8'hAA);
        chk("unmapped_wr", {31'd0, bus.uart_din_valid}, 32'd0);
        rd(32'h8000_0008, 32'd0, "wo_reg_read");
        rd(32'h0000_0000, 32'd0, "unmapped_rd");

        // RX single byte
        bus.uart_dout = 8'h55;
        bus.uart_dout_valid = 1'b1;
        @(negedge clk);
        bus.uart_dout_valid = 1'b0;
        rd(32'h8000_0004, 32'd1, "rx_vld1");
        rd(32'h8000_000C, 32'h55, "rx_data");
        rd(32'h8000_0004, 32'd0, "rx_vld0");
        rd(32'h8000_000C, 32'd0, "rx_empty_rd");

        // RX overrun
        for (int i = 0; i < 4; i++) begin
            bus.uart_dout = 8'h60 + 8'(i);
            bus.uart_dout_valid = 1'b1;
            @(negedge clk);
        end
        bus.uart_dout = 8'h99;
        @(negedge clk);
        chk("ovr_ready", {31'd0, bus.uart_dout_ready}, 32'd0);
        rd(32'h8000_0010, 32'd2, "ovr_set");
        wr(32'h8000_0010, 8'h00);
        rd(32'h8000_0010, 32'd2, "ovr_set_wins");
        bus.uart_dout_valid = 1'b0;
        wr(32'h8000_0010, 8'h00);
        rd(32'h8000_0010, 32'd0, "ovr_cleared");
        for (int i = 0; i < 4; i++) rd(32'h8000_000C, 32'h60 + i, "ovr_drain");
        rd(32'h8000_0004, 32'd0, "ovr_empty");

        // Same-cycle RX pop and push at count 2
        for (int i = 0; i < 2; i++) begin
            bus.uart_dout = 8'h70 + 8'(i);
            bus.uart_dout_valid = 1'b1;
            @(negedge clk);
        end
        bus.uart_dout = 8'h72;
        bus.io_re = 1'b1;
        bus.io_addr = 32'h8000_000C;
        @(negedge clk);
        bus.io_re = 1'b0;
        bus.uart_dout_valid = 1'b0;
        chk("conc_pop", bus.io_rdata, 32'h70);
        rd(32'h8000_000C, 32'h71, "conc_order1");
        rd(32'h8000_000C, 32'h72, "conc_order2");
        rd(32'h8000_0004, 32'd0, "conc_empty");

        // Asynchronous reset mid-stream
        wr(32'h8000_0008, 8'hC1);
        wr(32'h8000_0008, 8'hC2);
        for (int i = 0; i < 4; i++) begin
            bus.uart_dout = 8'hD0 + 8'(i);
            bus.uart_dout_valid = 1'b1;
            @(negedge clk);
        end
        bus.uart_dout_valid = 1'b0;
        rd(32'h8000_0004, 32'd1, "pre_rst_rxvld");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rdata", bus.io_rdata, 32'd0);
        chk("arst_din_valid", {31'd0, bus.uart_din_valid}, 32'd0);
        chk("arst_dout_ready", {31'd0, bus.uart_dout_ready}, 32'd1);
        @(negedge clk);
        bus.io_we = 1'b1;
        bus.io_addr = 32'h8000_0008;
        bus.io_wdata = 8'hEE;
        bus.uart_dout_valid = 1'b1;
        @(negedge clk);
        bus.io_we = 1'b0;
        bus.uart_dout_valid = 1'b0;
        rst_n = 1'b1;
        chk("post_rst_din_valid", {31'd0, bus.uart_din_valid}, 32'd0);
        rd(32'h8000_0004, 32'd0, "post_rst_rxvld");
        rd(32'h8000_0010, 32'd0, "post_rst_status");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
